aes_block_packer: RTL and testbench

- Sits between the OCL register-write FIFO stage (write_to_fifo) and the AES core in cl_aes.
- Consumes 32-bit words popped from the FIFO and assembles them into 128-bit key and plaintext blocks.
- Launches the AES core, captures the 128-bit ciphertext, and streams it back as four 32-bit words for register readout.

---
 rtl/aes_block_packer_if.sv | 27 ++
 rtl/aes_block_packer.sv | 140 ++++++++++++++
 tb/tb_aes_block_packer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_packer_if.sv
// Handshake and AES-core bus between the register-write FIFO, the packer and the AES core.
// The slave modport is the packer's view; master is the surrounding logic (FIFO, core, reader).
interface aes_block_packer_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_sel;
  logic [127:0] aes_key;
  logic         aes_key_load;
  logic [127:0] aes_pt;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_ct;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;

  modport master (
    output in_valid, in_data, in_sel, aes_done, aes_ct, out_ready,
    input  in_ready, aes_key, aes_key_load, aes_pt, aes_start, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, aes_done, aes_ct, out_ready,
    output in_ready, aes_key, aes_key_load, aes_pt, aes_start, out_valid, out_data
  );
endinterface

// File: rtl/aes_block_packer.sv
// Packs 32-bit FIFO words into 128-bit AES key/plaintext blocks, launches the core and
// streams the 128-bit ciphertext back out as four big-endian 32-bit words.
module aes_block_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned BLK_CNT_W      = 16
) (
  input  logic                 clk_main_a0,
  input  logic                 rst_main_n_sync,
  input  logic                 soft_clr,
  aes_block_packer_if.slave    bus,
  output logic [BLK_CNT_W-1:0] blk_count,
  output logic                 key_loaded,
  output logic                 err_no_key,
  output logic                 err_timeout
);

  localparam int unsigned     TmoW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StCollect, StLaunch, StWait, StDrain} state_e;

  state_e               r_state, w_state_next;
  logic [127:0]         r_key, r_pt, r_ct;
  logic [1:0]           r_kidx, r_didx, r_oidx;
  logic                 r_key_load, r_key_loaded, r_err_no_key, r_err_timeout;
  logic [BLK_CNT_W-1:0] r_blk_cnt;
  logic [TmoW-1:0]      r_tmo_cnt;

  logic w_in_ready, w_aes_start, w_out_valid;
  logic w_accept, w_key_wr, w_data_wr, w_key_last, w_data_last;
  logic w_out_acc, w_out_last, w_done, w_tmo;

  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_key_wr    = w_accept & bus.in_sel;
  assign w_data_wr   = w_accept & ~bus.in_sel;
  assign w_key_last  = w_key_wr & (r_kidx == 2'd3);
  assign w_data_last = w_data_wr & (r_didx == 2'd3);
  assign w_out_acc   = w_out_valid & bus.out_ready;
  assign w_out_last  = w_out_acc & (r_oidx == 2'd3);
  assign w_done      = (r_state == StWait) & bus.aes_done;
  // Counter counts cycles since aes_start, so it hits TmoLast TIMEOUT_CYCLES-1 cycles later.
  assign w_tmo       = (r_state == StWait) & ~bus.aes_done & (r_tmo_cnt == TmoLast);

  always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
    if (!rst_main_n_sync) r_state <= StCollect;
    else                  r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (soft_clr) begin
      w_state_next = StCollect;
    end else begin
      unique case (r_state)
        StCollect: if (w_data_last && r_key_loaded) w_state_next = StLaunch;
        StLaunch:  w_state_next = StWait;
        StWait:    if (w_done) w_state_next = StDrain;
                   else if (w_tmo) w_state_next = StCollect;
        StDrain:   if (w_out_last) w_state_next = StCollect;
        default:   w_state_next = StCollect;
      endcase
    end
  end

  // Handshake outputs are gated by reset and soft_clr so nothing transfers in those cycles.
  always_comb begin
    w_in_ready  = 1'b0;
    w_aes_start = 1'b0;
    w_out_valid = 1'b0;
    if (rst_main_n_sync && !soft_clr) begin
      unique case (r_state)
        StCollect: w_in_ready  = 1'b1;
        StLaunch:  w_aes_start = 1'b1;
        StDrain:   w_out_valid = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
    if (!rst_main_n_sync) begin
      r_key         <= '0;
      r_pt          <= '0;
      r_ct          <= '0;
      r_kidx        <= '0;
      r_didx        <= '0;
      r_oidx        <= '0;
      r_key_load    <= 1'b0;
      r_key_loaded  <= 1'b0;
      r_err_no_key  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_blk_cnt     <= '0;
      r_tmo_cnt     <= '0;
    end else begin
      r_key_load <= w_key_last;
      if (soft_clr) begin
        r_kidx        <= '0;
        r_didx        <= '0;
        r_oidx        <= '0;
        r_err_no_key  <= 1'b0;
        r_err_timeout <= 1'b0;
        r_tmo_cnt     <= '0;
      end else begin
        // Big-endian: index 0 lands in bits [127:96].
        if (w_key_wr) begin
          r_key[{~r_kidx, 5'd0} +: 32] <= bus.in_data;
          r_kidx                       <= r_kidx + 2'd1;
          if (w_key_last) r_key_loaded <= 1'b1;
        end
        if (w_data_wr) begin
          r_pt[{~r_didx, 5'd0} +: 32] <= bus.in_data;
          r_didx                      <= r_didx + 2'd1;
          if (w_data_last && !r_key_loaded) r_err_no_key <= 1'b1;
        end
        if (r_state == StLaunch || r_state == StWait) r_tmo_cnt <= r_tmo_cnt + 1'b1;
        else                                          r_tmo_cnt <= '0;
        if (w_tmo)  r_err_timeout <= 1'b1;
        if (w_done) r_ct <= bus.aes_ct;
        if (w_out_acc) begin
          r_oidx <= r_oidx + 2'd1;
          if (w_out_last) r_blk_cnt <= r_blk_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.aes_key      = r_key;
  assign bus.aes_key_load = r_key_load;
  assign bus.aes_pt       = r_pt;
  assign bus.aes_start    = w_aes_start;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_data     = r_ct[{~r_oidx, 5'd0} +: 32];

  assign blk_count   = r_blk_cnt;
  assign key_loaded  = r_key_loaded;
  assign err_no_key  = r_err_no_key;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: directed vector table, hand sequences for error/clear/reset
// corners, and a randomized word stream checked against a word-array block model.
module tb_aes_block_packer;
  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        soft_clr = 1'b0;
  logic [15:0] blk_count;
  logic        key_loaded, err_no_key, err_timeout;

  aes_block_packer_if bus();

  aes_block_packer #(.TIMEOUT_CYCLES(TMO), .BLK_CNT_W(16)) dut (
    .clk_main_a0    (clk),
    .rst_main_n_sync(rst_n),
    .soft_clr       (soft_clr),
    .bus            (bus),
    .blk_count      (blk_count),
    .key_loaded     (key_loaded),
    .err_no_key     (err_no_key),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ct_fn(input logic [127:0] k, input logic [127:0] p);
    return {p[63:0], p[127:64]} ^ k ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
  endfunction

  // ---------------- AES core model ----------------
  int           core_delay = 10;
  bit           core_fixed = 1'b0;
  logic [127:0] core_ct_fixed = '0;
  bit           core_busy = 1'b0;
  int           core_cnt = 0;
  logic [127:0] core_k, core_p;
  int           n_starts = 0;
  bit           start_chk = 1'b0;
  logic [255:0] exp_start_q[$];

  always @(negedge clk) begin
    if (bus.aes_start) begin
      n_starts++;
      core_busy = 1'b1;
      core_cnt  = core_delay;
      core_k    = bus.aes_key;
      core_p    = bus.aes_pt;
      if (start_chk) begin
        if (exp_start_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got pt %h expected no start", bus.aes_pt);
        end else begin
          logic [255:0] e;
          e = exp_start_q.pop_front();
          chk("start_key", bus.aes_key, e[255:128]);
          chk("start_pt", bus.aes_pt, e[127:0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bus.aes_done = 1'b0;
    if (core_busy && core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        bus.aes_done = 1'b1;
        bus.aes_ct   = core_fixed ? core_ct_fixed : ct_fn(core_k, core_p);
        core_busy    = 1'b0;
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [31:0] got_q[$];
  bit          hold_pend = 1'b0;
  logic [31:0] hold_word;

  always @(negedge clk) begin
    if (hold_pend && bus.out_valid) chk("out_hold", {96'd0, bus.out_data}, {96'd0, hold_word});
    hold_pend = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
    end else if (bus.out_valid) begin
      hold_pend = 1'b1;
      hold_word = bus.out_data;
    end
  end

  // ---------------- drivers ----------------
  int rmode = 0;  // 0 always ready, 1 toggle, 2 random

  function automatic logic next_ready(input int c);
    logic [31:0] cv;
    cv = c;
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return cv[0];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [31:0] d, output bit ok);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      bus.out_ready = next_ready(i);
      @(negedge clk);
      ok = bus.in_ready;
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_accept: got no in_ready expected accept of %h", d);
    end
  endtask

  task automatic wait_words(input int n, input string name);
    int c;
    c = 0;
    while (got_q.size() < n && c < 600) begin
      bus.out_ready = next_ready(c);
      tick();
      c++;
    end
    chk(name, 128'(got_q.size()), 128'(n));
  endtask

  task automatic pulse_clr();
    soft_clr = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", {127'd0, bus.in_ready}, 128'd0);
    chk("clr_out_valid", {127'd0, bus.out_valid}, 128'd0);
    tick();
    soft_clr = 1'b0;
  endtask

  task automatic send_blk(input bit sel, input logic [127:0] blk);
    bit ok;
    for (int w = 0; w < 4; w++) send(sel, blk[127 - 32*w -: 32], ok);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           delay;   // 0: core never answers
    int           rmode;
    bit           tmo;
  } vec_t;

  vec_t tbl[5];

  // ---------------- reference model for random stream ----------------
  logic [31:0] mk[4];
  logic [31:0] md[4];
  int          mki, mdi;
  bit          mloaded, merr;
  logic [31:0] exp_w[$];
  int          blk_total = 0;

  task automatic model_word(input bit sel, input logic [31:0] d);
    logic [127:0] k, p, c;
    if (sel) begin
      mk[mki] = d;
      mki = (mki + 1) % 4;
      if (mki == 0) mloaded = 1'b1;
    end else begin
      md[mdi] = d;
      mdi = (mdi + 1) % 4;
      if (mdi == 0) begin
        if (mloaded) begin
          k = {mk[0], mk[1], mk[2], mk[3]};
          p = {md[0], md[1], md[2], md[3]};
          c = ct_fn(k, p);
          exp_start_q.push_back({k, p});
          for (int w = 0; w < 4; w++) exp_w.push_back(c[127 - 32*w -: 32]);
          blk_total++;
        end else begin
          merr = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [127:0] k, p, c, ekey;
    logic [31:0]  a, b;
    logic [31:0]  pw[6];
    int           b0, s0;
    bit           ok, sel;
    logic [31:0]  d;

    tbl[0] = '{128'h00010203_04050607_08090A0B_0C0D0E0F, 128'h00112233_44556677_8899AABB_CCDDEEFF,
               128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A, 10, 0, 1'b0};
    tbl[1] = '{128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE, 128'h11111111_22222222_33333333_44444444,
               128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0, 1, 1, 1'b0};
    tbl[2] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
               128'h13579BDF_2468ACE0_FDB97531_0ECA8642, 15, 2, 1'b0};
    tbl[3] = '{128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3, 128'h55555555_AAAAAAAA_55555555_AAAAAAAA,
               128'h01010101_02020202_03030303_04040404, 0, 0, 1'b1};
    tbl[4] = '{128'h31415926_53589793_23846264_33832795, 128'h27182818_28459045_23536028_74713527,
               128'h99999999_88888888_77777777_66666666, 16, 0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_sel    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", {127'd0, bus.in_ready}, 128'd0);
    chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst_aes_start", {127'd0, bus.aes_start}, 128'd0);
    chk("rst_key_load", {127'd0, bus.aes_key_load}, 128'd0);
    chk("rst_aes_key", bus.aes_key, 128'd0);
    chk("rst_aes_pt", bus.aes_pt, 128'd0);
    chk("rst_out_data", {96'd0, bus.out_data}, 128'd0);
    chk("rst_status", {108'd0, blk_count, key_loaded, err_no_key, err_timeout}, 128'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {127'd0, bus.in_ready}, 128'd1);

    // Data block with no key: error, no launch
    core_fixed = 1'b0;
    core_delay = 5;
    send_blk(1'b0, 128'h10203040_50607080_90A0B0C0_D0E0F000);
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("nokey_err", {127'd0, err_no_key}, 128'd1);
    chk("nokey_starts", 128'(n_starts), 128'd0);
    chk("nokey_in_ready", {127'd0, bus.in_ready}, 128'd1);
    chk("nokey_key_loaded", {127'd0, key_loaded}, 128'd0);
    k = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
    p = 128'h3243F6A8_885A308D_313198A2_E0370734;
    got_q.delete();
    send_blk(1'b1, k);
    send_blk(1'b0, p);
    bus.in_valid = 1'b0;
    wait_words(4, "nokey_recover_count");
    c = ct_fn(k, p);
    for (int w = 0; w < 4; w++)
      chk("nokey_recover_word", {96'd0, got_q[w]}, {96'd0, c[127 - 32*w -: 32]});
    blk_total = 1;
    chk("nokey_recover_blk", {112'd0, blk_count}, 128'(blk_total));
    chk("nokey_err_sticky", {127'd0, err_no_key}, 128'd1);

    // Vector table
    core_fixed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse_clr();
      core_ct_fixed = tbl[i].ct;
      core_delay    = tbl[i].delay;
      rmode         = 0;
      got_q.delete();
      b0 = blk_total;
      s0 = n_starts;
      for (int w = 0; w < 4; w++) begin
        send(1'b1, tbl[i].key[127 - 32*w -: 32], ok);
      end
      chk("key_load_pulse", {127'd0, bus.aes_key_load}, 128'd1);
      chk("key_loaded", {127'd0, key_loaded}, 128'd1);
      chk("aes_key", bus.aes_key, tbl[i].key);
      for (int w = 0; w < 4; w++) begin
        send(1'b0, tbl[i].pt[127 - 32*w -: 32], ok);
        if (w == 0) chk("key_load_single", {127'd0, bus.aes_key_load}, 128'd0);
      end
      bus.in_valid = 1'b0;
      chk("aes_start_latency", {127'd0, bus.aes_start}, 128'd1);
      chk("aes_pt", bus.aes_pt, tbl[i].pt);
      chk("launch_in_ready", {127'd0, bus.in_ready}, 128'd0);
      rmode = tbl[i].rmode;
      if (tbl[i].tmo) begin
        repeat (15) tick();
        chk("tmo_not_early", {127'd0, err_timeout}, 128'd0);
        tick();
        chk("tmo_set", {127'd0, err_timeout}, 128'd1);
        chk("tmo_in_ready", {127'd0, bus.in_ready}, 128'd1);
        repeat (5) tick();
        chk("tmo_no_output", 128'(got_q.size()), 128'd0);
        chk("tmo_out_valid", {127'd0, bus.out_valid}, 128'd0);
      end else begin
        wait_words(4, "blk_word_count");
        for (int w = 0; w < 4; w++)
          chk("ct_word", {96'd0, got_q[w]}, {96'd0, tbl[i].ct[127 - 32*w -: 32]});
        blk_total++;
        chk("blk_in_ready", {127'd0, bus.in_ready}, 128'd1);
      end
      chk("blk_count", {112'd0, blk_count}, 128'(blk_total));
      chk("start_count", 128'(n_starts - s0), 128'd1);
      if (b0 + (tbl[i].tmo ? 0 : 1) != blk_total) chk("blk_delta", 128'd0, 128'd1);
    end

    // Interleaved K,D,K,D then soft_clr; key regs partially updated, data index cleared
    core_fixed = 1'b0;
    core_delay = 3;
    rmode      = 0;
    a = 32'hA1A2A3A4;
    b = 32'hB1B2B3B4;
    for (int w = 0; w < 6; w++) pw[w] = 32'h0C0C0000 + 32'(w * 32'h1111);
    ekey = {a, b, tbl[4].key[63:0]};
    chk("pre_clr_err", {127'd0, err_timeout}, 128'd1);
    send(1'b1, a, ok);
    send(1'b0, pw[0], ok);
    send(1'b1, b, ok);
    send(1'b0, pw[1], ok);
    bus.in_sel  = 1'b0;
    bus.in_data = pw[2];
    pulse_clr();
    chk("clr_err_cleared", {126'd0, err_no_key, err_timeout}, 128'd0);
    chk("clr_key_loaded", {127'd0, key_loaded}, 128'd1);
    chk("clr_key_retained", bus.aes_key, ekey);
    got_q.delete();
    start_chk = 1'b1;
    p = {pw[2], pw[3], pw[4], pw[5]};
    exp_start_q.push_back({ekey, p});
    for (int w = 2; w < 6; w++) send(1'b0, pw[w], ok);
    bus.in_valid = 1'b0;
    wait_words(4, "intlv_word_count");
    c = ct_fn(ekey, p);
    for (int w = 0; w < 4; w++)
      chk("intlv_word", {96'd0, got_q[w]}, {96'd0, c[127 - 32*w -: 32]});
    blk_total++;
    chk("intlv_blk", {112'd0, blk_count}, 128'(blk_total));

    // Randomized stream against the model
    pulse_clr();
    got_q.delete();
    exp_w.delete();
    for (int w = 0; w < 4; w++) mk[w] = ekey[127 - 32*w -: 32];
    mki = 0;
    mdi = 0;
    mloaded = 1'b1;
    merr = 1'b0;
    rmode = 2;
    for (int n = 0; n < 160; n++) begin
      sel = ($urandom_range(0, 3) == 0);
      d = $urandom;
      core_delay = $urandom_range(1, 15);
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          bus.out_ready = next_ready(0);
          tick();
        end
      end
      send(sel, d, ok);
      if (ok) model_word(sel, d);
    end
    bus.in_valid = 1'b0;
    wait_words(exp_w.size(), "rand_word_count");
    for (int w = 0; w < exp_w.size(); w++)
      chk("rand_word", {96'd0, got_q[w]}, {96'd0, exp_w[w]});
    chk("rand_blk", {112'd0, blk_count}, 128'(blk_total & 32'hFFFF));
    chk("rand_err_no_key", {127'd0, err_no_key}, {127'd0, merr});
    chk("rand_starts_left", 128'(exp_start_q.size()), 128'd0);
    start_chk = 1'b0;

    // Reset while draining drops out_valid immediately
    pulse_clr();
    rmode = 0;
    core_delay = 2;
    send_blk(1'b0, 128'h0BAD0BAD_FACEFACE_12121212_34343434);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 30 && !bus.out_valid; i++) tick();
    chk("drain_out_valid", {127'd0, bus.out_valid}, 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("midrst_in_ready", {127'd0, bus.in_ready}, 128'd0);
    chk("midrst_status", {108'd0, blk_count, key_loaded, err_no_key, err_timeout}, 128'd0);
    chk("midrst_key", bus.aes_key, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_release_in_ready", {127'd0, bus.in_ready}, 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
